// File: rtl/memcached_udp_parser_pkg.sv
// Shared definitions for the memcached UDP ingress parser: FSM states, opcodes,
// ASCII command constants, UDP port default and beat positions within a frame.
package memcached_udp_parser_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_CMD   = 3'd2,
      ST_SIZE  = 3'd3,
      ST_VALUE = 3'd4,
      ST_SKIP  = 3'd5,
      ST_DRAIN = 3'd6,
      ST_EMIT  = 3'd7
   } state_t;

   localparam logic        OP_GET             = 1'b0;
   localparam logic        OP_SET             = 1'b1;
   localparam logic [23:0] ASCII_SET          = 24'h736574;
   localparam logic [23:0] ASCII_GET          = 24'h676574;
   localparam logic [7:0]  ASCII_SP           = 8'h20;
   localparam logic [15:0] C_UDP_PORT_DEFAULT = 16'h2BCB;

   localparam logic [4:0]  PORT_BEAT     = 5'd4;
   localparam logic [4:0]  HDR_LAST_BEAT = 5'd5;
   localparam logic [4:0]  CMD_BEAT      = 5'd6;
   localparam logic [4:0]  VALUE_BEAT0   = 5'd8;
   localparam logic [4:0]  BEAT_MAX      = 5'd31;

   // Command bytes 2..4 of the command beat, in wire order ("set" reads 's','e','t').
   function automatic logic [23:0] cmd_chars(input logic [63:0] d);
      return {d[23:16], d[31:24], d[39:32]};
   endfunction

endpackage

// File: rtl/memcached_udp_parser.sv
// Ethernet/IPv4/UDP memcached ingress parser: filters UDP port, decodes "set"/"get",
// emits one command per good frame. Optional counters under `MEMCACHED_STATS_EN.
module memcached_udp_parser
   import memcached_udp_parser_pkg::*;
#(
   parameter int          C_S_AXIS_DATA_WIDTH  = 64,
   parameter int          C_S_AXIS_TUSER_WIDTH = 128,
   parameter logic [15:0] C_UDP_PORT           = C_UDP_PORT_DEFAULT,
   parameter int          C_VALUE_WORDS        = 8
) (
   input  logic                              axi_aclk,
   input  logic                              axi_resetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,
   output logic                              cmd_valid,
   input  logic                              cmd_ready,
   output logic                              cmd_op,
   output logic [7:0]                        cmd_key,
   output logic [64*C_VALUE_WORDS-1:0]       cmd_value,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   cmd_tuser,
   output logic                              drop_pulse
`ifdef MEMCACHED_STATS_EN
   ,
   output logic [31:0]                       stat_set_cnt,
   output logic [31:0]                       stat_get_cnt,
   output logic [31:0]                       stat_drop_cnt
`endif
);

   localparam int         VW         = 64 * C_VALUE_WORDS;
   localparam logic [4:0] VALUE_LAST = 5'(VALUE_BEAT0 + 5'(C_VALUE_WORDS) - 5'd1);

   state_t     state_r;
   logic [4:0] beat_cnt_r;
   logic       ready_en_r;
   logic       beat_s;
   logic       port_ok_s;
   logic       delims_ok_s;
   logic       is_set_s;
   logic       is_get_s;
   logic       tstrb_unused_s;

   // Strobes carry no information the parser needs; frames are beat-granular.
   assign tstrb_unused_s = ^s_axis_tstrb;

   assign s_axis_tready = ready_en_r && (state_r != ST_EMIT);
   assign beat_s        = s_axis_tvalid && s_axis_tready;
   assign port_ok_s     = ({s_axis_tdata[39:32], s_axis_tdata[47:40]} == C_UDP_PORT);
   assign delims_ok_s   = (s_axis_tdata[47:40] == ASCII_SP) && (s_axis_tdata[63:56] == ASCII_SP);
   assign is_set_s      = delims_ok_s && (cmd_chars(s_axis_tdata) == ASCII_SET);
   assign is_get_s      = delims_ok_s && (cmd_chars(s_axis_tdata) == ASCII_GET);

   // Parser FSM, beat counter and registered command/drop outputs.
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_r    <= ST_IDLE;
         beat_cnt_r <= 5'd0;
         ready_en_r <= 1'b0;
         cmd_valid  <= 1'b0;
         cmd_op     <= OP_GET;
         cmd_key    <= 8'h00;
         cmd_value  <= '0;
         cmd_tuser  <= '0;
         drop_pulse <= 1'b0;
      end else begin
         ready_en_r <= 1'b1;
         drop_pulse <= 1'b0;
         if (beat_s) begin
            if (s_axis_tlast)
               beat_cnt_r <= 5'd0;
            else if (beat_cnt_r != BEAT_MAX)
               beat_cnt_r <= beat_cnt_r + 5'd1;
         end
         case (state_r)
            ST_IDLE: if (beat_s) begin
               cmd_tuser <= s_axis_tuser;
               cmd_value <= '0;
               cmd_op    <= OP_GET;
               cmd_key   <= 8'h00;
               if (s_axis_tlast) drop_pulse <= 1'b1;
               else              state_r    <= ST_HDR;
            end
            ST_HDR: if (beat_s) begin
               if (s_axis_tlast) begin
                  drop_pulse <= 1'b1;
                  state_r    <= ST_IDLE;
               end else if (beat_cnt_r == PORT_BEAT && !port_ok_s)
                  state_r <= ST_DRAIN;
               else if (beat_cnt_r == HDR_LAST_BEAT)
                  state_r <= ST_CMD;
            end
            ST_CMD: if (beat_s) begin
               // A GET is complete at the command beat; a SET still needs its value.
               if (is_get_s) begin
                  cmd_op    <= OP_GET;
                  cmd_key   <= s_axis_tdata[55:48];
                  cmd_valid <= s_axis_tlast;
                  state_r   <= s_axis_tlast ? ST_EMIT : ST_SKIP;
               end else if (is_set_s && !s_axis_tlast) begin
                  cmd_op  <= OP_SET;
                  cmd_key <= s_axis_tdata[55:48];
                  state_r <= ST_SIZE;
               end else if (s_axis_tlast) begin
                  drop_pulse <= 1'b1;
                  state_r    <= ST_IDLE;
               end else
                  state_r <= ST_DRAIN;
            end
            ST_SIZE: if (beat_s) begin
               if (s_axis_tlast) begin
                  drop_pulse <= 1'b1;
                  state_r    <= ST_IDLE;
               end else
                  state_r <= ST_VALUE;
            end
            ST_VALUE: if (beat_s) begin
               cmd_value <= {s_axis_tdata, cmd_value[VW-1:64]};
               if (beat_cnt_r == VALUE_LAST) begin
                  cmd_valid <= s_axis_tlast;
                  state_r   <= s_axis_tlast ? ST_EMIT : ST_SKIP;
               end else if (s_axis_tlast) begin
                  drop_pulse <= 1'b1;
                  state_r    <= ST_IDLE;
               end
            end
            ST_SKIP: if (beat_s && s_axis_tlast) begin
               cmd_valid <= 1'b1;
               state_r   <= ST_EMIT;
            end
            ST_DRAIN: if (beat_s && s_axis_tlast) begin
               drop_pulse <= 1'b1;
               state_r    <= ST_IDLE;
            end
            ST_EMIT: if (cmd_ready) begin
               cmd_valid <= 1'b0;
               state_r   <= ST_IDLE;
            end
            default: begin
               cmd_valid <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef MEMCACHED_STATS_EN
   // Free-running wrap-around event counters for SET/GET handshakes and drops.
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         stat_set_cnt  <= 32'd0;
         stat_get_cnt  <= 32'd0;
         stat_drop_cnt <= 32'd0;
      end else begin
         if (cmd_valid && cmd_ready && cmd_op == OP_SET) stat_set_cnt <= stat_set_cnt + 32'd1;
         if (cmd_valid && cmd_ready && cmd_op == OP_GET) stat_get_cnt <= stat_get_cnt + 32'd1;
         if (drop_pulse) stat_drop_cnt <= stat_drop_cnt + 32'd1;
      end
   end
`endif

endmodule
